// File: rtl/class_scheduler_if.sv
// FIFO-side and egress-side signals of the class scheduler.
// master = environment (FIFOs + downstream), slave = scheduler.
interface class_scheduler_if #(
  parameter int DATA_W = 12
);
  logic              enable;
  logic              out_pause;
  logic [3:0]        fifo_empty;
  logic [DATA_W-1:0] fifo_data0;
  logic [DATA_W-1:0] fifo_data1;
  logic [DATA_W-1:0] fifo_data2;
  logic [DATA_W-1:0] fifo_data3;
  logic [3:0]        fifo_pop;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        class_out;
  logic              valid_out;

  modport master (
    output enable, out_pause, fifo_empty,
    output fifo_data0, fifo_data1, fifo_data2, fifo_data3,
    input  fifo_pop, data_out, class_out, valid_out
  );

  modport slave (
    input  enable, out_pause, fifo_empty,
    input  fifo_data0, fifo_data1, fifo_data2, fifo_data3,
    output fifo_pop, data_out, class_out, valid_out
  );
endinterface

// File: rtl/class_scheduler.sv
// Weighted round-robin drain of four class FIFOs onto one egress channel,
// with per-class burst weights, backpressure and a tagged output register.
module class_scheduler #(
  parameter int DATA_W = 12,
  parameter int W0     = 4,
  parameter int W1     = 2,
  parameter int W2     = 1,
  parameter int W3     = 1
) (
  input logic             clk,
  input logic             reset,
  class_scheduler_if.slave bus
);

  if (W0 < 1 || W0 > 15 || W1 < 1 || W1 > 15 ||
      W2 < 1 || W2 > 15 || W3 < 1 || W3 > 15) begin : g_bad_weight
    $error("class_scheduler: every class weight must lie in 1..15");
  end

  typedef enum logic {IDLE, SERVE} state_t;

  state_t      st, st_n;
  logic [1:0]  cur, cur_n;
  logic [1:0]  ptr, ptr_n;
  logic [3:0]  cnt, cnt_n;
  logic        go;
  logic [3:0]  pop_oh;
  logic [1:0]  pop_idx;
  logic [2:0]  srch_ptr;
  logic [2:0]  srch_nxt;

  logic              vld_p1;
  logic [1:0]        cls_p1;
  logic [DATA_W-1:0] sel_data;
  logic              vld_p2;
  logic [1:0]        cls_p2;
  logic [DATA_W-1:0] data_p2;

  function automatic logic [3:0] weight_of(input logic [1:0] c);
    logic [3:0] w;
    case (c)
      2'd0:    w = 4'(W0);
      2'd1:    w = 4'(W1);
      2'd2:    w = 4'(W2);
      default: w = 4'(W3);
    endcase
    return w;
  endfunction

  // {hit, class}: first non-empty class scanning start, start+1, ... mod 4
  function automatic logic [2:0] search(input logic [3:0] empty, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = start + 2'(i);
      if (!empty[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign go       = bus.enable & ~bus.out_pause & ~reset;
  assign srch_ptr = search(bus.fifo_empty, ptr);
  assign srch_nxt = search(bus.fifo_empty, cur + 2'd1);

  always_comb begin
    pop_oh  = 4'b0000;
    pop_idx = cur;
    st_n    = st;
    cur_n   = cur;
    cnt_n   = cnt;
    ptr_n   = ptr;
    if (go) begin
      case (st)
        IDLE: begin
          if (srch_ptr[2]) begin
            pop_idx = srch_ptr[1:0];
            pop_oh  = 4'b0001 << srch_ptr[1:0];
            cur_n   = srch_ptr[1:0];
            cnt_n   = 4'd1;
            st_n    = SERVE;
          end
        end
        SERVE: begin
          if (!bus.fifo_empty[cur] && (cnt < weight_of(cur))) begin
            pop_idx = cur;
            pop_oh  = 4'b0001 << cur;
            cnt_n   = cnt + 4'd1;
          end else if (srch_nxt[2]) begin
            // Hand the turn over in the same cycle so no bubble appears.
            pop_idx = srch_nxt[1:0];
            pop_oh  = 4'b0001 << srch_nxt[1:0];
            cur_n   = srch_nxt[1:0];
            cnt_n   = 4'd1;
            ptr_n   = srch_nxt[1:0] + 2'd1;
          end else begin
            ptr_n = cur + 2'd1;
            st_n  = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_pop = pop_oh;

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= IDLE;
      cur <= 2'd0;
      cnt <= 4'd0;
      ptr <= 2'd0;
    end else begin
      st  <= st_n;
      cur <= cur_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
    end
  end

  // p1: pop issued last cycle; FIFO read data is valid this cycle
  always_ff @(posedge clk) begin
    cls_p1 <= pop_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= |pop_oh;
  end

  always_comb begin
    case (cls_p1)
      2'd0:    sel_data = bus.fifo_data0;
      2'd1:    sel_data = bus.fifo_data1;
      2'd2:    sel_data = bus.fifo_data2;
      default: sel_data = bus.fifo_data3;
    endcase
  end

  // p2: registered egress word and class tag
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      cls_p2  <= 2'd0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= sel_data;
        cls_p2  <= cls_p1;
      end
    end
  end

  assign bus.valid_out = vld_p2;
  assign bus.data_out  = data_p2;
  assign bus.class_out = cls_p2;

endmodule

// File: tb/tb_class_scheduler.sv
// Table-driven bench for class_scheduler with a behavioural model of the
// four class FIFOs (registered read data, one word per pop).
module tb_class_scheduler;

  logic clk;
  logic reset;

  class_scheduler_if #(.DATA_W(12)) bus ();

  class_scheduler #(
    .DATA_W(12), .W0(4), .W1(2), .W2(1), .W3(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: level and next word per class, reloaded by load_en
  logic [5:0]  lvl      [4];
  logic [11:0] nxtw     [4];
  logic [11:0] fdat     [4];
  logic [5:0]  cfg_lvl  [4];
  logic [11:0] cfg_base [4];
  logic        load_en;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load_en) begin
        lvl[i]  <= cfg_lvl[i];
        nxtw[i] <= cfg_base[i];
      end else if (bus.fifo_pop[i] && lvl[i] != 6'd0) begin
        lvl[i]  <= lvl[i] - 6'd1;
        nxtw[i] <= nxtw[i] + 12'd1;
        fdat[i] <= nxtw[i];
      end
    end
  end

  assign bus.fifo_empty = {lvl[3] == 6'd0, lvl[2] == 6'd0, lvl[1] == 6'd0, lvl[0] == 6'd0};
  assign bus.fifo_data0 = fdat[0];
  assign bus.fifo_data1 = fdat[1];
  assign bus.fifo_data2 = fdat[2];
  assign bus.fifo_data3 = fdat[3];

  typedef struct {
    logic       en;
    logic       pause;
    logic       rst;
    logic       ld;
    logic [3:0] exp_pop;
  } vec_t;

  vec_t tbl[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected egress pipeline: e1 = pop of previous cycle, e2 = two cycles ago
  logic        e1_v, e2_v;
  logic [1:0]  e1_c, e2_c, hold_c;
  logic [11:0] e1_d, e2_d, hold_d;
  int          popped [4];

  task automatic add(input logic en, input logic pause, input logic rst,
                     input logic ld, input logic [3:0] exp_pop);
    vec_t v;
    v.en = en; v.pause = pause; v.rst = rst; v.ld = ld; v.exp_pop = exp_pop;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic clear_expect();
    e1_v = 1'b0; e2_v = 1'b0;
    e1_c = 2'd0; e2_c = 2'd0; hold_c = 2'd0;
    e1_d = 12'd0; e2_d = 12'd0; hold_d = 12'd0;
    for (int i = 0; i < 4; i++) popped[i] = 0;
  endtask

  // Reset for n cycles with everything enabled; FIFOs are loaded in the first cycle.
  task automatic do_reset(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset = 1'b1; bus.enable = 1'b1; bus.out_pause = 1'b0;
      load_en = (k == 0);
      #1;
      chk({nm, "_rst_pop"}, k, 32'(bus.fifo_pop), 32'h0);
      if (k > 0) begin
        chk({nm, "_rst_valid"}, k, 32'(bus.valid_out), 32'h0);
        chk({nm, "_rst_data"},  k, 32'(bus.data_out),  32'h0);
        chk({nm, "_rst_class"}, k, 32'(bus.class_out), 32'h0);
      end
    end
    clear_expect();
  endtask

  task automatic run(input string nm, input int first, input int last);
    vec_t       v;
    logic [1:0] c;
    for (int i = first; i <= last; i++) begin
      v = tbl[i];
      @(posedge clk); #1;
      bus.enable = v.en; bus.out_pause = v.pause; reset = v.rst; load_en = v.ld;
      #1;
      chk({nm, "_pop"},   i, 32'(bus.fifo_pop),  32'(v.exp_pop));
      chk({nm, "_valid"}, i, 32'(bus.valid_out), 32'(e2_v));
      if (e2_v) begin
        hold_d = e2_d;
        hold_c = e2_c;
      end
      chk({nm, "_data"},  i, 32'(bus.data_out),  32'(hold_d));
      chk({nm, "_class"}, i, 32'(bus.class_out), 32'(hold_c));
      if (v.rst) begin
        e1_v = 1'b0; e2_v = 1'b0; hold_d = 12'd0; hold_c = 2'd0;
      end else begin
        e2_v = e1_v; e2_c = e1_c; e2_d = e1_d;
        e1_v = |v.exp_pop;
        if (e1_v) begin
          c = oh2idx(v.exp_pop);
          e1_c = c;
          e1_d = cfg_base[c] + 12'(popped[c]);
          popped[c]++;
        end
      end
      if (v.ld) for (int k = 0; k < 4; k++) popped[k] = 0;
    end
    load_en = 1'b0;
  endtask

  int s_rr, e_rr, s_c2, e_c2, s_e1, e_e1, s_e2, e_e2, s_rm, e_rm;

  initial begin
    reset = 1'b1; load_en = 1'b0; bus.enable = 1'b0; bus.out_pause = 1'b0;
    clear_expect();

    // Round robin with all FIFOs deep, then pause and enable hold mid-burst
    s_rr = tbl.size();
    for (int r = 0; r < 2; r++) begin
      add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
      add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0100); add(1,0,0,0,4'b1000);
    end
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    for (int r = 0; r < 4; r++) add(1,1,0,0,4'b0000);
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0100); add(1,0,0,0,4'b1000);
    add(1,0,0,0,4'b0001);
    add(0,0,0,0,4'b0000); add(0,0,0,0,4'b0000);
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0100); add(1,0,0,0,4'b1000);
    e_rr = tbl.size() - 1;

    // Only class 2 holds five words
    s_c2 = tbl.size();
    for (int r = 0; r < 5; r++) add(1,0,0,0,4'b0100);
    for (int r = 0; r < 3; r++) add(1,0,0,0,4'b0000);
    e_c2 = tbl.size() - 1;

    // Class 1 runs dry early, everything drains to IDLE
    s_e1 = tbl.size();
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0100); add(1,0,0,0,4'b1000);
    add(1,0,0,0,4'b0000); add(1,0,0,0,4'b0000);
    e_e1 = tbl.size() - 1;
    // Refill class 3 alone while idle
    s_e2 = tbl.size();
    add(1,0,0,1,4'b0000);
    add(1,0,0,0,4'b1000); add(1,0,0,0,4'b1000);
    add(1,0,0,0,4'b0000); add(1,0,0,0,4'b0000); add(1,0,0,0,4'b0000);
    e_e2 = tbl.size() - 1;

    // One-cycle reset in the middle of a class-0 burst
    s_rm = tbl.size();
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    add(1,0,1,0,4'b0000);
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0010);
    add(1,0,0,0,4'b0001); add(1,0,0,0,4'b0001);
    add(1,0,0,0,4'b0000); add(1,0,0,0,4'b0000); add(1,0,0,0,4'b0000);
    e_rm = tbl.size() - 1;

    cfg_lvl  = '{6'd40, 6'd40, 6'd40, 6'd40};
    cfg_base = '{12'h101, 12'h201, 12'h301, 12'h401};
    do_reset("rr", 3);
    run("rr", s_rr, e_rr);

    cfg_lvl  = '{6'd0, 6'd0, 6'd5, 6'd0};
    cfg_base = '{12'h101, 12'h201, 12'h001, 12'h401};
    do_reset("c2", 2);
    run("c2", s_c2, e_c2);

    cfg_lvl  = '{6'd4, 6'd1, 6'd1, 6'd1};
    cfg_base = '{12'h111, 12'h211, 12'h311, 12'h411};
    do_reset("empty", 2);
    run("empty", s_e1, e_e1);
    cfg_lvl  = '{6'd0, 6'd0, 6'd0, 6'd2};
    cfg_base = '{12'h111, 12'h211, 12'h311, 12'h4a1};
    run("refill", s_e2, e_e2);

    cfg_lvl  = '{6'd8, 6'd2, 6'd0, 6'd0};
    cfg_base = '{12'h121, 12'h221, 12'h321, 12'h421};
    do_reset("midrst", 2);
    run("midrst", s_rm, e_rm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
